// File: rtl/lcd_placar_if.sv
// Score/LCD bus bundle between the game top level, the LCD writer and the board LCD pins.
// The master side drives the score request; the slave side (the writer) drives the LCD pins.
interface lcd_placar_if;
    logic [23:0] placar;
    logic        enablePlacar;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_EN;
    logic        lcdBusy;
    logic        placarDone;

    modport master (
        output placar, enablePlacar,
        input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, lcdBusy, placarDone
    );

    modport slave (
        input  placar, enablePlacar,
        output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, lcdBusy, placarDone
    );
endinterface

// File: rtl/lcd_placar.sv
// HD44780 8-bit character-LCD writer: power-up wait, init sequence, then writes the
// three-character score at line 1 column 0 on every rising edge of enablePlacar.
module lcd_placar #(
    parameter int unsigned PWRUP_WAIT_CYCLES = 1000000,
    parameter int unsigned EN_HIGH_CYCLES    = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input logic         CLK,
    input logic         i_rst,
    lcd_placar_if.slave bus
);

    localparam int unsigned MaxA      = (PWRUP_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                                        PWRUP_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int unsigned MaxB      = (CMD_WAIT_CYCLES > EN_HIGH_CYCLES) ?
                                        CMD_WAIT_CYCLES : EN_HIGH_CYCLES;
    localparam int unsigned MaxCycles = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] PwrupLast = CntW'(PWRUP_WAIT_CYCLES - 1);
    localparam logic [CntW-1:0] EnLast    = CntW'(EN_HIGH_CYCLES - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StPwrup, StInit, StIdle, StFrame} state_e;
    typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_e;

    state_e          r_state, w_state;
    phase_e          r_phase, w_phase;
    logic [CntW-1:0] r_cnt, w_cnt;
    logic [1:0]      r_idx, w_idx;
    logic [7:0]      r_lcd_data, w_lcd_data;
    logic            r_lcd_rs, w_lcd_rs;
    logic            r_en;
    logic            r_done, w_done;
    logic            r_prev;
    logic            r_pending, w_pending;
    logic [23:0]     r_shadow;
    logic [23:0]     r_work;
    logic            w_req;
    logic            w_frame_start;
    logic [CntW-1:0] w_hold_last;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [23:0] work);
        case (idx)
            2'd0:    return 8'h80;
            2'd1:    return work[23:16];
            2'd2:    return work[15:8];
            default: return work[7:0];
        endcase
    endfunction

    assign w_req         = bus.enablePlacar & ~r_prev;
    assign w_frame_start = (r_state == StFrame) && (r_idx == 2'd0) && (r_phase == PhSetup);
    // Set wins over the frame-start clear so a request in that cycle is not dropped.
    assign w_pending     = w_req | (r_pending & ~w_frame_start);
    // Only the clear-display command (RS=0, 0x01) needs the long settle time.
    assign w_hold_last   = (!r_lcd_rs && r_lcd_data == 8'h01) ? ClearLast : CmdLast;

    always_comb begin
        w_state    = r_state;
        w_phase    = r_phase;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_lcd_data = r_lcd_data;
        w_lcd_rs   = r_lcd_rs;
        w_done     = 1'b0;
        unique case (r_state)
            StPwrup: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == PwrupLast) begin
                    w_state    = StInit;
                    w_phase    = PhSetup;
                    w_cnt      = '0;
                    w_idx      = '0;
                    w_lcd_data = init_byte(2'd0);
                    w_lcd_rs   = 1'b0;
                end
            end
            StIdle: begin
                if (r_pending) begin
                    w_state    = StFrame;
                    w_phase    = PhSetup;
                    w_cnt      = '0;
                    w_idx      = '0;
                    w_lcd_data = 8'h80;
                    w_lcd_rs   = 1'b0;
                end
            end
            StInit, StFrame: begin
                w_cnt = r_cnt + 1'b1;
                unique case (r_phase)
                    PhSetup: begin
                        w_phase = PhStrobe;
                        w_cnt   = '0;
                    end
                    PhStrobe: begin
                        if (r_cnt == EnLast) begin
                            w_phase = PhHold;
                            w_cnt   = '0;
                        end
                    end
                    PhHold: begin
                        if (r_cnt == w_hold_last) begin
                            w_phase = PhSetup;
                            w_cnt   = '0;
                            if (r_idx != 2'd3) begin
                                w_idx      = r_idx + 2'd1;
                                w_lcd_rs   = (r_state == StFrame);
                                w_lcd_data = (r_state == StFrame) ? frame_byte(w_idx, r_work)
                                                                  : init_byte(w_idx);
                            end else begin
                                w_idx  = '0;
                                w_done = (r_state == StFrame);
                                // Go straight into a new frame so lcdBusy never dips.
                                if (r_pending) begin
                                    w_state    = StFrame;
                                    w_lcd_data = 8'h80;
                                    w_lcd_rs   = 1'b0;
                                end else begin
                                    w_state = StIdle;
                                end
                            end
                        end
                    end
                    default: begin
                        w_phase = PhSetup;
                        w_cnt   = '0;
                    end
                endcase
            end
            default: w_state = StPwrup;
        endcase
    end

    always_ff @(posedge CLK or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StPwrup;
            r_phase    <= PhSetup;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_lcd_data <= '0;
            r_lcd_rs   <= 1'b0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_prev     <= 1'b0;
            r_pending  <= 1'b0;
            r_shadow   <= '0;
            r_work     <= '0;
        end else begin
            r_state    <= w_state;
            r_phase    <= w_phase;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_lcd_data <= w_lcd_data;
            r_lcd_rs   <= w_lcd_rs;
            r_en       <= (w_phase == PhStrobe);
            r_done     <= w_done;
            r_prev     <= bus.enablePlacar;
            r_pending  <= w_pending;
            if (w_req) begin
                r_shadow <= bus.placar;
            end
            if (w_frame_start) begin
                r_work <= r_shadow;
            end
        end
    end

    assign bus.LCD_DATA   = r_lcd_data;
    assign bus.LCD_RS     = r_lcd_rs;
    assign bus.LCD_RW     = 1'b0;
    assign bus.LCD_EN     = r_en;
    assign bus.lcdBusy    = (r_state != StIdle);
    assign bus.placarDone = r_done;

endmodule

// File: doc/lcd_placar.md
# lcd_placar

Character-LCD writer for the Pong scoreboard. It consumes the `placar`/`enablePlacar` pair produced by the game top level. It initialises an HD44780-compatible 16x2 LCD in 8-bit mode, then writes the three-byte ASCII score to line 1, column 0 on every request. It sits between the game top level and the board LCD pins and runs on the 50 MHz board clock.

## Interface
- `PWRUP_WAIT_CYCLES`, default 1000000: idle cycles after reset before the first command (20 ms).
- `EN_HIGH_CYCLES`, default 25: cycles `LCD_EN` is held high per byte (500 ns).
- `CMD_WAIT_CYCLES`, default 2500: cycles `LCD_EN` is low after a byte (50 us).
- `CLEAR_WAIT_CYCLES`, default 100000: cycles `LCD_EN` is low after the 0x01 clear command (2 ms).
- `CLK  in  1`: board clock; all logic is on its rising edge.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `placar  in  24`: score characters, with `[23:16]` first, `[15:8]` second and `[7:0]` third, all ASCII.
- `enablePlacar  in  1`: write request; a rising edge requests a write.
- `LCD_DATA  out  8`: LCD data bus.
- `LCD_RS  out  1`: 0 selects a command, 1 selects character data.
- `LCD_RW  out  1`: tied to 0; the block only writes.
- `LCD_EN  out  1`: LCD enable strobe.
- `lcdBusy  out  1`: high during init or while a frame is being written.
- `placarDone  out  1`: one-cycle pulse when a frame completes.

## Operation
- States: PWRUP, INIT, IDLE, FRAME.
- Every byte goes through one slot with three phases:
  - SETUP: 1 cycle. `LCD_RS` and `LCD_DATA` are driven to the new values and `LCD_EN` is 0.
  - STROBE: `EN_HIGH_CYCLES` cycles with `LCD_EN` = 1.
  - HOLD: wait cycles with `LCD_EN` = 0. The wait is `CLEAR_WAIT_CYCLES` for the 0x01 command and `CMD_WAIT_CYCLES` for every other byte.
- `LCD_RS` and `LCD_DATA` stay stable through the whole slot.
- PWRUP: count `PWRUP_WAIT_CYCLES`, then go to INIT.
- INIT: send the commands 0x38, 0x0C, 0x06, 0x01 in that order, all with RS=0. Then go to IDLE.
- IDLE: `lcdBusy` = 0. A pending request moves the block to FRAME.
- FRAME: send command 0x80 (RS=0), then the characters `placar[23:16]`, `[15:8]`, `[7:0]` (RS=1). Pulse `placarDone` and return to IDLE.
- Request detect: `enablePlacar` is registered into `prev`, which resets to 0. A request is `enablePlacar & ~prev`.
  - On a request cycle, `placar` is captured into a 24-bit shadow register and a `pending` flag is set.
  - A level held high does not retrigger.
- Requests arriving in PWRUP, INIT or FRAME are not lost:
  - The shadow register is overwritten with the newest `placar`, so the latest score wins. There is no queue.
  - `pending` stays set.
  - FRAME latches the shadow into a working register and clears `pending` on its first cycle.
  - A request landing in that same cycle re-sets `pending` (set has priority over clear).
- After FRAME, `pending` = 1 causes a new FRAME to start on the next cycle.
- A request coincident with FRAME completion is served by the next FRAME.
- Mid-operation reset: all state clears immediately, `LCD_EN` drops in the same instant, and the block restarts in PWRUP. A pending request is discarded.
- If `enablePlacar` is already high when reset is released, it counts as an edge on the first clock.

## Timing
- Reset values:
  - `LCD_DATA` = 0x00, `LCD_RS` = 0, `LCD_RW` = 0, `LCD_EN` = 0.
  - `lcdBusy` = 1, `placarDone` = 0.
  - State PWRUP; `pending`, `prev` and the shadow register are 0.
- Slot length is 1 + `EN_HIGH_CYCLES` + wait.
- Init duration from reset release is `PWRUP_WAIT_CYCLES` + 3·(1+EN_HIGH+CMD) + (1+EN_HIGH+CLEAR).
- Frame duration is 4·(1+EN_HIGH+CMD).
- Request-to-first-SETUP latency from IDLE is 2 cycles: edge registered, then FRAME entered.
- `placarDone` is high for the single cycle in which `lcdBusy` falls. If FRAME restarts immediately, `lcdBusy` stays high and `placarDone` still pulses.
- Counter widths are sized for the largest parameter; 20 bits covers the defaults.

## Test plan
All scenarios use PWRUP=10, EN_HIGH=2, CMD=4, CLEAR=8, so a normal slot is 7 cycles.
- Reset release with no request: the bus shows 0x38, 0x0C, 0x06 (7-cycle slots), then 0x01 (11 cycles), all with RS=0. `lcdBusy` falls exactly 42 cycles after release and `LCD_EN` is high 2 cycles per byte.
- After init, `placar`=0x313A32 ("1:2") with a 1-cycle `enablePlacar` pulse: the bus shows 0x80 (RS=0), then 0x31, 0x3A, 0x32 (RS=1). `placarDone` pulses once 28 cycles after the first SETUP.
- Hold `enablePlacar` high for 100 cycles: exactly one frame is written.
- Mid-frame, pulse requests with 0x303A30 and then 0x313A30: the current frame completes unchanged, then exactly one extra frame writes 0x31, 0x3A, 0x30.
- Request during INIT with 0x323A31: the frame starts 1 cycle after INIT would end, `lcdBusy` never falls in between, and the data is 0x32, 0x3A, 0x31.
- Assert `i_rst` during the STROBE of the second character: `LCD_EN`=0 immediately and all outputs return to reset values. After release the full 42-cycle init repeats and no frame follows.
